// File: rtl/key_debounce.sv
// Conditions active-low push-buttons into a clean level plus single-cycle
// press / release / long-press pulses, one independent channel per key.
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX    = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE    = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Two-flop synchronizer; idles at 1 so a reset looks like "all released".
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            state_t              state_reg;
            state_t              state_next;
            logic [DEB_W-1:0]    deb_cnt_reg;
            logic [DEB_W-1:0]    deb_cnt_next;
            logic [LONG_W-1:0]   long_cnt_reg;
            logic [LONG_W-1:0]   long_cnt_next;
            logic                level_reg;
            logic                level_next;
            logic                press_reg;
            logic                press_next;
            logic                release_reg;
            logic                release_next;
            logic                long_reg;
            logic                long_next;
            logic                s;

            assign s = sync2_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= IDLE;
                    deb_cnt_reg  <= '0;
                    long_cnt_reg <= '0;
                    level_reg    <= 1'b0;
                    press_reg    <= 1'b0;
                    release_reg  <= 1'b0;
                    long_reg     <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    deb_cnt_reg  <= deb_cnt_next;
                    long_cnt_reg <= long_cnt_next;
                    level_reg    <= level_next;
                    press_reg    <= press_next;
                    release_reg  <= release_next;
                    long_reg     <= long_next;
                end
            end

            always_comb begin
                state_next    = state_reg;
                deb_cnt_next  = deb_cnt_reg;
                long_cnt_next = long_cnt_reg;
                press_next    = 1'b0;
                release_next  = 1'b0;
                long_next     = 1'b0;

                case (state_reg)
                    IDLE: begin
                        if (!s) begin
                            state_next   = PRESS_WAIT;
                            deb_cnt_next = '0;
                        end
                    end

                    PRESS_WAIT: begin
                        if (s) begin
                            state_next   = IDLE;
                            deb_cnt_next = '0;
                        end else if (deb_cnt_reg == DEB_MAX) begin
                            state_next    = PRESSED;
                            press_next    = 1'b1;
                            deb_cnt_next  = '0;
                            long_cnt_next = '0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end

                    PRESSED: begin
                        // Saturating count: the pulse fires once, on the step to LONG_MAX.
                        if (long_cnt_reg < LONG_MAX) begin
                            long_cnt_next = long_cnt_reg + 1'b1;
                            long_next     = (long_cnt_reg == LONG_PRE);
                        end
                        if (s) begin
                            state_next   = RELEASE_WAIT;
                            deb_cnt_next = '0;
                        end
                    end

                    RELEASE_WAIT: begin
                        if (!s) begin
                            state_next   = PRESSED;
                            deb_cnt_next = '0;
                        end else if (deb_cnt_reg == DEB_MAX) begin
                            state_next   = IDLE;
                            release_next = 1'b1;
                            deb_cnt_next = '0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end

                    default: begin
                        state_next   = IDLE;
                        deb_cnt_next = '0;
                    end
                endcase

                level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            end

            assign key_state[gi]   = level_reg;
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;
            assign key_long[gi]    = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: the driver queues expected output events,
// the monitor pops and compares whenever any output changes or pulses.
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    key_debounce #(
        .N_KEYS(4),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] state;
    } ev_t;

    ev_t  sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] last_state = 4'b0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] s);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.state = s;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
            errors++;
            $display("FAIL %s: state=%b press=%b release=%b long=%b, all required 0",
                     name, key_state, key_press, key_release, key_long);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            last_state = key_state;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: expected at cyc=%0d press=%b release=%b long=%b state=%b, now cyc=%0d",
                         sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng, sb[0].state, cyc);
                void'(sb.pop_front());
            end
            if (key_press != 4'b0 || key_release != 4'b0 || key_long != 4'b0 || key_state != last_state) begin
                $display("event cyc=%0d press=%b release=%b long=%b state=%b",
                         cyc, key_press, key_release, key_long, key_state);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d press=%b release=%b long=%b state=%b, none required",
                             cyc, key_press, key_release, key_long, key_state);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL event_time: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
                    end
                    checks++;
                    if ({key_press, key_release, key_long, key_state} !== {e.press, e.rel, e.lng, e.state}) begin
                        errors++;
                        $display("FAIL event_value: got press=%b release=%b long=%b state=%b, required press=%b release=%b long=%b state=%b",
                                 key_press, key_release, key_long, key_state, e.press, e.rel, e.lng, e.state);
                    end
                end
            end
            last_state = key_state;
        end
    end

    // Driver: an input changed at negedge with cyc=c is first sampled at edge c+1,
    // so its qualified event is visible at cyc = c+1+10.
    initial begin
        int c;
        rst_n = 1'b0;
        key_n = 4'hF;
        #50;
        check_zero("reset_state");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press / release on key 0
        c = cyc; key_n[0] = 1'b0;
        push_ev(c + 11, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(20);
        c = cyc; key_n[0] = 1'b1;
        push_ev(c + 11, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cyc(15);

        // Bounce on key 1: must produce nothing
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0; wait_cyc(3);
            key_n[1] = 1'b1; wait_cyc(3);
        end
        wait_cyc(15);
        checks++;
        if (key_state !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_state: state=%b, required 0000", key_state);
        end

        // Long press on key 2, then release with bounce
        c = cyc; key_n[2] = 1'b0;
        push_ev(c + 11, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push_ev(c + 43, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        wait_cyc(60);
        key_n[2] = 1'b1; wait_cyc(4);
        key_n[2] = 1'b0; wait_cyc(2);
        c = cyc; key_n[2] = 1'b1;
        push_ev(c + 11, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_cyc(15);

        // Simultaneous press on keys 0 and 3
        c = cyc; key_n[0] = 1'b0; key_n[3] = 1'b0;
        push_ev(c + 11, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        wait_cyc(20);
        c = cyc; key_n[0] = 1'b1; key_n[3] = 1'b1;
        push_ev(c + 11, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        wait_cyc(15);

        // Reset five cycles into PRESS_WAIT with key 0 held
        key_n[0] = 1'b0;
        wait_cyc(8);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_zero("mid_reset");
            wait_cyc(1);
        end
        c = cyc; rst_n = 1'b1;
        push_ev(c + 11, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(20);
        c = cyc; key_n[0] = 1'b1;
        push_ev(c + 11, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

        for (int i = 0; i < 40 && sb.size() > 0; i++) wait_cyc(1);
        wait_cyc(5);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_event: expected cyc=%0d press=%b release=%b long=%b state=%b never seen",
                     sb[0].cyc, sb[0].press, sb[0].rel, sb[0].lng, sb[0].state);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
